// File: rtl/interpolator.sv
// -----------------------------------------------------------------------------
// interpolator
//   Polyphase FIR upsampler. Each accepted input sample is shifted into a
//   TAPS_PER_PHASE-deep delay line. FACTOR output samples are then produced,
//   one per polyphase branch, in phase order 0..FACTOR-1:
//     y_p = sat((sum_k h[k*FACTOR+p] * x[k]) >>> SHIFT)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   data_in holds a sample
//   in_ready   block accepts data_in this cycle (decoded from state, 0 in reset)
//   data_in    signed input sample, DATA_WIDTH bits
//   coeff      packed signed taps, h[j] = coeff[j*COEFF_WIDTH +: COEFF_WIDTH]
//   out_valid  data_out holds an output sample (decoded from state)
//   out_ready  consumer accepts data_out
//   data_out   signed registered output sample
// -----------------------------------------------------------------------------
module interpolator #(
  parameter int unsigned DATA_WIDTH     = 12,
  parameter int unsigned COEFF_WIDTH    = 8,
  parameter int unsigned FACTOR         = 2,
  parameter int unsigned TAPS_PER_PHASE = 4,
  parameter int unsigned SHIFT          = 7
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [DATA_WIDTH-1:0]                         data_in,
  input  logic [COEFF_WIDTH*FACTOR*TAPS_PER_PHASE-1:0]  coeff,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_WIDTH-1:0]                         data_out
);

  localparam int unsigned T       = TAPS_PER_PHASE;
  localparam int unsigned NTAPS   = FACTOR * TAPS_PER_PHASE;
  localparam int unsigned PROD_W  = DATA_WIDTH + COEFF_WIDTH;
  localparam int unsigned ACC_W   = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS_PER_PHASE);
  localparam int unsigned PW      = (FACTOR > 1) ? $clog2(FACTOR) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_WIDTH - 1)));
  localparam logic [PW-1:0]           P_LAST  = PW'(FACTOR - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [PW-1:0]                 p_q, p_d;
  logic signed [DATA_WIDTH-1:0]  x_q [T];
  logic signed [DATA_WIDTH-1:0]  x_d [T];
  logic [DATA_WIDTH-1:0]         data_q, data_d;

  // Unpack the flat coefficient bus into signed taps
  logic signed [COEFF_WIDTH-1:0] h [NTAPS];

  for (genvar j = 0; j < NTAPS; j++) begin : g_taps
    assign h[j] = coeff[j*COEFF_WIDTH +: COEFF_WIDTH];
  end

  // Polyphase MAC for the current phase, with shift and saturation
  logic signed [COEFF_WIDTH-1:0] hsel;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       shifted;
  logic [DATA_WIDTH-1:0]         y;

  always_comb begin
    acc  = '0;
    hsel = '0;
    prod = '0;
    for (int k = 0; k < T; k++) begin
      // Constant-indexed phase mux keeps every tap select in range
      hsel = '0;
      for (int ph = 0; ph < FACTOR; ph++) begin
        if (p_q == PW'(ph)) begin
          hsel = h[k*FACTOR + ph];
        end
      end
      prod = PROD_W'(x_q[k]) * PROD_W'(hsel);
      acc  = acc + ACC_W'(prod);
    end
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX) begin
      y = DATA_WIDTH'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      y = DATA_WIDTH'(SAT_MIN);
    end else begin
      y = DATA_WIDTH'(shifted);
    end
  end

  // Next-state, handshake decode and datapath update
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    x_d       = x_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset gates in_ready so nothing is accepted on a reset edge
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          x_d[0] = data_in;
          for (int k = 1; k < T; k++) begin
            x_d[k] = x_q[k-1];
          end
          p_d     = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        // Coefficients are only consumed here
        data_d  = y;
        state_d = EMIT;
      end

      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (p_q < P_LAST) begin
            p_d     = PW'(p_q + 1'b1);
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      data_q  <= '0;
      for (int k = 0; k < T; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      data_q  <= data_d;
      for (int k = 0; k < T; k++) begin
        x_q[k] <= x_d[k];
      end
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_interpolator.sv
// -----------------------------------------------------------------------------
// tb_interpolator
//   Directed bench for interpolator. Two instances share all inputs: dut0 uses
//   SHIFT=0, dut7 uses the default SHIFT=7. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_interpolator;

  localparam int unsigned DW    = 12;
  localparam int unsigned CW    = 8;
  localparam int unsigned L     = 2;
  localparam int unsigned T     = 4;
  localparam int unsigned CBITS = CW * L * T;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             out_ready;
  logic [DW-1:0]    data_in;
  logic [CBITS-1:0] coeff;

  logic             in_ready0, out_valid0, in_ready7, out_valid7;
  logic [DW-1:0]    dout0, dout7;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  interpolator #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FACTOR(L), .TAPS_PER_PHASE(T), .SHIFT(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .data_in(data_in), .coeff(coeff), .out_valid(out_valid0),
    .out_ready(out_ready), .data_out(dout0)
  );

  interpolator #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .FACTOR(L), .TAPS_PER_PHASE(T), .SHIFT(7)
  ) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7),
    .data_in(data_in), .coeff(coeff), .out_valid(out_valid7),
    .out_ready(out_ready), .data_out(dout7)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_coeffs();
    coeff = '0;
  endtask

  task automatic set_coeff(input int idx, input int val);
    coeff[idx*CW +: CW] = CW'(val);
  endtask

  task automatic impulse_coeffs();
    for (int j = 0; j < 8; j++) set_coeff(j, j + 1);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // Offer one sample and hold it until accepted (bounded)
  task automatic send_sample(input int v);
    int n;
    n        = 0;
    data_in  = DW'(v);
    in_valid = 1'b1;
    while (!in_ready0 && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for an output and handshake it; X on timeout
  task automatic collect(input bit sel7, output logic [DW-1:0] v);
    int n;
    n = 0;
    while (!(sel7 ? out_valid7 : out_valid0) && n < 50) begin
      step();
      n++;
    end
    if (sel7 ? out_valid7 : out_valid0) v = sel7 ? dout7 : dout0;
    else v = 'x;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    data_in   = DW'(55);
    clear_coeffs();
    step();
    vectors++;
    if (in_ready0 !== 1'b0 || in_ready7 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b/%b, want 0/0", in_ready0, in_ready7);
    end
    vectors++;
    if (out_valid0 !== 1'b0 || out_valid7 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b/%b, want 0/0", out_valid0, out_valid7);
    end
    vectors++;
    if (dout0 !== '0 || dout7 !== '0) begin
      miscompares++;
      $display("FAIL reset_data_out: got %0d/%0d, want 0/0", $signed(dout0), $signed(dout7));
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    vectors++;
    if (in_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_idle: in_ready got %b, want 1", in_ready0);
    end
  endtask

  task automatic test_handshake_timing();
    clear_coeffs();
    set_coeff(0, 1);
    set_coeff(1, 1);
    do_reset();
    data_in  = DW'(7);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL calc_flags: got ov=%b ir=%b, want ov=0 ir=0", out_valid0, in_ready0);
    end
    step();
    vectors++;
    if (out_valid0 !== 1'b1 || dout0 !== DW'(7) || in_ready0 !== 1'b0) begin
      miscompares++;
      $display("FAIL first_output: got ov=%b d=%0d ir=%b, want ov=1 d=7 ir=0",
               out_valid0, $signed(dout0), in_ready0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (out_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_after_hs0: out_valid got %b, want 0", out_valid0);
    end
    step();
    vectors++;
    if (out_valid0 !== 1'b1 || dout0 !== DW'(7)) begin
      miscompares++;
      $display("FAIL second_output: got ov=%b d=%0d, want ov=1 d=7", out_valid0, $signed(dout0));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_idle: got ov=%b ir=%b, want ov=0 ir=1", out_valid0, in_ready0);
    end
  endtask

  task automatic test_hold();
    int ins [2] = '{100, -5};
    logic [DW-1:0] v;
    clear_coeffs();
    set_coeff(0, 1);
    set_coeff(1, 1);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_sample(ins[i]);
      for (int ph = 0; ph < 2; ph++) begin
        collect(1'b0, v);
        vectors++;
        if (v !== DW'(ins[i])) begin
          miscompares++;
          $display("FAIL hold[%0d.%0d]: got %0d, want %0d", i, ph, $signed(v), ins[i]);
        end
      end
    end
  endtask

  task automatic test_impulse();
    int ins  [5]  = '{10, 0, 0, 0, 0};
    int exps [10] = '{10, 20, 30, 40, 50, 60, 70, 80, 0, 0};
    logic [DW-1:0] v;
    clear_coeffs();
    impulse_coeffs();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_sample(ins[i]);
      for (int ph = 0; ph < 2; ph++) begin
        collect(1'b0, v);
        vectors++;
        if (v !== DW'(exps[2*i + ph])) begin
          miscompares++;
          $display("FAIL impulse[%0d]: got %0d, want %0d", 2*i + ph, $signed(v), exps[2*i + ph]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int ins  [2] = '{2047, -2048};
    int exps [4] = '{2047, 0, -2048, 0};
    logic [DW-1:0] v;
    clear_coeffs();
    set_coeff(0, 127);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_sample(ins[i]);
      for (int ph = 0; ph < 2; ph++) begin
        collect(1'b0, v);
        vectors++;
        if (v !== DW'(exps[2*i + ph])) begin
          miscompares++;
          $display("FAIL saturate[%0d]: got %0d, want %0d", 2*i + ph, $signed(v), exps[2*i + ph]);
        end
      end
    end
  endtask

  task automatic test_default_shift();
    int ins  [2] = '{1000, -1000};
    int exps [4] = '{500, 0, -500, 0};
    logic [DW-1:0] v;
    clear_coeffs();
    set_coeff(0, 64);
    do_reset();
    for (int i = 0; i < 2; i++) begin
      send_sample(ins[i]);
      for (int ph = 0; ph < 2; ph++) begin
        collect(1'b1, v);
        vectors++;
        if (v !== DW'(exps[2*i + ph])) begin
          miscompares++;
          $display("FAIL shift7[%0d]: got %0d, want %0d", 2*i + ph, $signed(v), exps[2*i + ph]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exps [2] = '{30, 40};
    logic [DW-1:0] v;
    int n;
    clear_coeffs();
    impulse_coeffs();
    do_reset();
    send_sample(10);
    n = 0;
    while (!out_valid0 && n < 50) begin
      step();
      n++;
    end
    vectors++;
    if (out_valid0 !== 1'b1 || dout0 !== DW'(10)) begin
      miscompares++;
      $display("FAIL bp_first: got ov=%b d=%0d, want ov=1 d=10", out_valid0, $signed(dout0));
    end
    // Stall five cycles, poke in_valid and scramble coeff meanwhile
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      data_in  = DW'(999);
      if (c == 0) clear_coeffs();
      step();
      vectors++;
      if (out_valid0 !== 1'b1 || dout0 !== DW'(10) || in_ready0 !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got ov=%b d=%0d ir=%b, want ov=1 d=10 ir=0",
                 c, out_valid0, $signed(dout0), in_ready0);
      end
    end
    in_valid = 1'b0;
    impulse_coeffs();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    collect(1'b0, v);
    vectors++;
    if (v !== DW'(20)) begin
      miscompares++;
      $display("FAIL bp_phase1: got %0d, want 20", $signed(v));
    end
    // Stalled in_valid pulses must not have shifted the delay line
    send_sample(0);
    for (int ph = 0; ph < 2; ph++) begin
      collect(1'b0, v);
      vectors++;
      if (v !== DW'(exps[ph])) begin
        miscompares++;
        $display("FAIL bp_after[%0d]: got %0d, want %0d", ph, $signed(v), exps[ph]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ins  [5]  = '{10, 0, 0, 0, 0};
    int exps [10] = '{10, 20, 30, 40, 50, 60, 70, 80, 0, 0};
    logic [DW-1:0] v;
    int n;
    clear_coeffs();
    impulse_coeffs();
    do_reset();
    send_sample(10);
    n = 0;
    while (!out_valid0 && n < 50) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || dout0 !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got ov=%b ir=%b d=%0d, want ov=0 ir=1 d=0",
               out_valid0, in_ready0, $signed(dout0));
    end
    for (int i = 0; i < 5; i++) begin
      send_sample(ins[i]);
      for (int ph = 0; ph < 2; ph++) begin
        collect(1'b0, v);
        vectors++;
        if (v !== DW'(exps[2*i + ph])) begin
          miscompares++;
          $display("FAIL post_reset_impulse[%0d]: got %0d, want %0d",
                   2*i + ph, $signed(v), exps[2*i + ph]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_handshake_timing();
    test_hold();
    test_impulse();
    test_saturation();
    test_default_shift();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
